// File: rtl/lhn_mem_arbiter.sv
// Single-port main-memory arbiter for the lhnRISC621 core.
// Arbitrates instruction fetch (IF), data load/store (DM) and stack (SK)
// requests, registers the memory command and returns read data two cycles
// after the grant to whichever requester issued the read.
module lhn_mem_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 14,
  parameter int STARVE_LIMIT = 3
) (
  input  logic          Clock_pin,
  input  logic          Resetn_pin,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  input  logic          sk_req,
  input  logic          sk_we,
  input  logic          sk_lock,
  input  logic [AW-1:0] sk_addr,
  input  logic [DW-1:0] sk_wdata,
  output logic          sk_gnt,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rdata,
  output logic          if_rvalid,
  output logic          dm_rvalid,
  output logic          sk_rvalid
);

  typedef enum logic {NORMAL, LOCKED} state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
  localparam logic [1:0] ID_IF = 2'd0;
  localparam logic [1:0] ID_DM = 2'd1;
  localparam logic [1:0] ID_SK = 2'd2;

  state_t        state_q, state_d;
  logic [2:0]    starve_cnt_q, starve_cnt_d;
  logic          if_g, dm_g, sk_g, any_g, wr_g;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic          rd_vld_p1_q, rd_vld_p1_d;
  logic [1:0]    rd_id_p1_q, rd_id_p1_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [2:0]    rvalid_q, rvalid_d;

  // Grant selection, lock FSM next state and starvation counter update.
  // Grants are forced low while reset is asserted so nothing leaks out.
  always_comb begin
    if_g         = 1'b0;
    dm_g         = 1'b0;
    sk_g         = 1'b0;
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    if (Resetn_pin) begin
      if (state_q == LOCKED && sk_req) begin
        sk_g = 1'b1;                     // second half of CALL/RET beats even a starving IF
      end else if (if_req && starve_cnt_q == LIMIT) begin
        if_g = 1'b1;
      end else if (dm_req) begin
        dm_g = 1'b1;
      end else if (sk_req) begin
        sk_g = 1'b1;
      end else if (if_req) begin
        if_g = 1'b1;
      end
      // Only a NORMAL-state stack grant can open a lock, so at most two in a row.
      state_d = (state_q == NORMAL && sk_g && sk_lock) ? LOCKED : NORMAL;
      if (!if_req || if_g) begin
        starve_cnt_d = 3'd0;
      end else if (dm_g || sk_g) begin
        starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT : starve_cnt_q + 3'd1;
      end
    end
  end

  // Memory command for the granted requester; address/data hold when idle.
  always_comb begin
    any_g       = if_g | dm_g | sk_g;
    wr_g        = (dm_g & dm_we) | (sk_g & sk_we);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_id_p1_d  = ID_IF;
    if (dm_g) begin
      mem_addr_d = dm_addr;
      rd_id_p1_d = ID_DM;
      if (dm_we) mem_wdata_d = dm_wdata;
    end else if (sk_g) begin
      mem_addr_d = sk_addr;
      rd_id_p1_d = ID_SK;
      if (sk_we) mem_wdata_d = sk_wdata;
    end else if (if_g) begin
      mem_addr_d = if_addr;
    end
    mem_we_d    = wr_g;
    rd_vld_p1_d = any_g & ~wr_g;
  end

  // Read return: capture memory data one cycle after the address is presented.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 3'b000;
    if (rd_vld_p1_q) begin
      rdata_d  = mem_rdata;
      rvalid_d = 3'b001 << rd_id_p1_q;
    end
  end

  // State, counter and pipeline registers; reset drops any read in flight.
  always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
    if (!Resetn_pin) begin
      state_q      <= NORMAL;
      starve_cnt_q <= 3'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      rd_vld_p1_q  <= 1'b0;
      rd_id_p1_q   <= ID_IF;
      rdata_q      <= '0;
      rvalid_q     <= 3'b000;
    end else begin
      // stage p0 -> p1: memory command registered, read tagged with requester
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      rd_vld_p1_q  <= rd_vld_p1_d;
      rd_id_p1_q   <= rd_id_p1_d;
      // stage p1 -> p2: read data returned to the tagged requester
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign if_gnt    = if_g;
  assign dm_gnt    = dm_g;
  assign sk_gnt    = sk_g;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign rdata     = rdata_q;
  assign if_rvalid = rvalid_q[ID_IF];
  assign dm_rvalid = rvalid_q[ID_DM];
  assign sk_rvalid = rvalid_q[ID_SK];

endmodule

// File: tb/tb_lhn_mem_arbiter.sv
// Scoreboard bench for lhn_mem_arbiter: a request-level model predicts the
// winner each cycle and queues the expected memory command and read return;
// an independent monitor compares those against the DUT outputs.
module tb_lhn_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 14;
  localparam int LIMIT = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          if_req = 1'b0, dm_req = 1'b0, sk_req = 1'b0;
  logic          dm_we = 1'b0, sk_we = 1'b0, sk_lock = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0, sk_addr = '0;
  logic [DW-1:0] dm_wdata = '0, sk_wdata = '0;
  logic          if_gnt, dm_gnt, sk_gnt, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, rdata;
  logic          if_rvalid, dm_rvalid, sk_rvalid;

  lhn_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .Clock_pin(clk), .Resetn_pin(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .sk_req(sk_req), .sk_we(sk_we), .sk_lock(sk_lock), .sk_addr(sk_addr), .sk_wdata(sk_wdata),
    .sk_gnt(sk_gnt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .rdata(rdata), .if_rvalid(if_rvalid), .dm_rvalid(dm_rvalid), .sk_rvalid(sk_rvalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: writes land on the edge ending the mem_we cycle; reads are asynchronous.
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] ref_mem [0:1023];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic lock;} req_t;
  typedef struct {int cyc; logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata;} mev_t;
  typedef struct {int cyc; int id; logic [DW-1:0] data;} rev_t;

  req_t q_if[$], q_dm[$], q_sk[$];
  req_t cur[3];
  bit   act[3];
  mev_t mev_q[$];
  rev_t rev_q[$];

  int  checks = 0, errors = 0;
  bit  m_locked = 0;
  int  m_loss = 0;
  int  last_win = -1;
  int  first_if = -1;
  bit  rand_mode = 0;

  task automatic chk(string name, logic [31:0] act_v, logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act_v, exp_v);
    end
  endtask

  // Request-level reference: decide winner, predict memory traffic.
  task automatic model_cycle();
    int win;
    req_t r;
    if (m_locked && sk_req)                win = 2;
    else if (if_req && m_loss == LIMIT)    win = 0;
    else if (dm_req)                       win = 1;
    else if (sk_req)                       win = 2;
    else if (if_req)                       win = 0;
    else                                   win = -1;
    chk("if_gnt", if_gnt, win == 0);
    chk("dm_gnt", dm_gnt, win == 1);
    chk("sk_gnt", sk_gnt, win == 2);
    if (win >= 0) begin
      r = cur[win];
      if (win == 0) r.we = 1'b0;
      mev_q.push_back('{cyc + 1, r.addr, r.we, r.wdata});
      if (r.we) ref_mem[r.addr] = r.wdata;
      else rev_q.push_back('{cyc + 2, win, ref_mem[r.addr]});
    end
    if (!if_req || win == 0) m_loss = 0;
    else if (win > 0 && m_loss < LIMIT) m_loss++;
    m_locked = (!m_locked && win == 2 && sk_lock);
    if (win == 0 && first_if < 0) first_if = cyc;
    last_win = win;
  endtask

  function automatic req_t rand_req(int id);
    req_t r;
    r.we    = (id == 0) ? 1'b0 : 1'($urandom_range(0, 1));
    r.addr  = AW'($urandom_range(0, 15));
    r.wdata = DW'($urandom);
    r.lock  = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Advance requesters: a granted or idle requester takes its next request.
  task automatic drive_next();
    for (int i = 0; i < 3; i++) begin
      if (!act[i] || last_win == i) begin
        act[i] = 1'b0;
        if (i == 0 && q_if.size() > 0) begin cur[i] = q_if.pop_front(); act[i] = 1'b1; end
        else if (i == 1 && q_dm.size() > 0) begin cur[i] = q_dm.pop_front(); act[i] = 1'b1; end
        else if (i == 2 && q_sk.size() > 0) begin cur[i] = q_sk.pop_front(); act[i] = 1'b1; end
        else if (rand_mode && $urandom_range(0, 2) == 0) begin cur[i] = rand_req(i); act[i] = 1'b1; end
      end
    end
    last_win = -1;
    if_req = act[0]; if_addr = cur[0].addr;
    dm_req = act[1]; dm_we = cur[1].we; dm_addr = cur[1].addr; dm_wdata = cur[1].wdata;
    sk_req = act[2]; sk_we = cur[2].we; sk_addr = cur[2].addr; sk_wdata = cur[2].wdata;
    sk_lock = cur[2].lock;
  endtask

  task automatic run(int n);
    repeat (n) begin
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
      drive_next();
    end
  endtask

  task automatic do_reset(int n);
    rstn = 1'b0;
    mev_q.delete();
    rev_q.delete();
    m_locked = 0;
    m_loss = 0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_gnt", {if_gnt, dm_gnt, sk_gnt}, 3'b000);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, '0);
      chk("rst_mem_wdata", mem_wdata, '0);
      chk("rst_rvalid", {if_rvalid, dm_rvalid, sk_rvalid}, 3'b000);
      chk("rst_rdata", rdata, '0);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Monitor: memory command and read return compared against queued predictions.
  always @(negedge clk) begin
    if (rstn) begin
      if (mev_q.size() > 0 && mev_q[0].cyc == cyc) begin
        mev_t e;
        e = mev_q.pop_front();
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", mem_we, e.we);
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
      end else begin
        chk("mem_we_idle", mem_we, 1'b0);
      end
      if (rev_q.size() > 0 && rev_q[0].cyc == cyc) begin
        rev_t e;
        e = rev_q.pop_front();
        chk("rvalid", {sk_rvalid, dm_rvalid, if_rvalid}, 3'b001 << e.id);
        chk("rdata", rdata, e.data);
      end else begin
        chk("rvalid_idle", {sk_rvalid, dm_rvalid, if_rvalid}, 3'b000);
      end
    end
  end

  initial begin
    int start;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = DW'(i * 37 + 5);
      ref_mem[i] = DW'(i * 37 + 5);
    end
    mem[5] = 14'h1A2B; ref_mem[5] = 14'h1A2B;
    for (int i = 0; i < 3; i++) begin act[i] = 1'b0; cur[i] = '{1'b0, '0, '0, 1'b0}; end

    // Reset with a fetch already requesting; first grant right after release.
    q_if.push_back('{1'b0, 10'h005, '0, 1'b0});
    q_if.push_back('{1'b0, 10'h006, '0, 1'b0});
    q_if.push_back('{1'b0, 10'h007, '0, 1'b0});
    drive_next();
    do_reset(3);
    run(8);

    // Store and fetch together: store first, fetch next cycle.
    q_dm.push_back('{1'b1, 10'h010, 14'h0123, 1'b0});
    q_if.push_back('{1'b0, 10'h010, '0, 1'b0});
    run(1);
    run(6);

    // Continuous stores against a held fetch: fetch forced on the 4th cycle.
    for (int i = 0; i < 6; i++) q_dm.push_back('{1'b1, AW'(10'h040 + i), DW'(14'h0100 + i), 1'b0});
    for (int i = 0; i < 2; i++) q_if.push_back('{1'b0, AW'(10'h040 + i), '0, 1'b0});
    run(1);
    first_if = -1;
    start = cyc;
    run(10);
    chk("starve_first_if", 32'(first_if - start), 32'd3);

    // Locked stack pair, data request arriving mid-lock, third locked push waits.
    q_sk.push_back('{1'b1, 10'h3F0, 14'h0ABC, 1'b1});
    q_sk.push_back('{1'b1, 10'h3EF, 14'h0123, 1'b1});
    q_sk.push_back('{1'b1, 10'h3EE, 14'h0555, 1'b1});
    run(1);
    q_dm.push_back('{1'b0, 10'h3F0, '0, 1'b0});
    run(8);

    // Store then load of the same address back to back.
    q_dm.push_back('{1'b1, 10'h020, 14'h3FFF, 1'b0});
    q_dm.push_back('{1'b0, 10'h020, '0, 1'b0});
    run(1);
    run(6);

    // Random traffic with a reset in the middle of it.
    rand_mode = 1;
    run(300);
    do_reset(2);
    run(300);
    rand_mode = 0;
    run(10);
    chk("drain_mem_events", mev_q.size(), 0);
    chk("drain_read_events", rev_q.size(), 0);
    chk("drain_requests", q_if.size() + q_dm.size() + q_sk.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lhn_mem_arbiter.md
Name: lhn_mem_arbiter

Overview:
Single-port arbiter for the shared von Neumann main memory (10-bit address, 14-bit data) in the lhnRISC621 core. It arbitrates between three requesters: instruction fetch (IF), data load/store (DM) and stack push/pop for CALL/RET (SK). It drives the memory address, write-data and write-enable, and routes the synchronous read data back to the requester that was granted. It sits between the pipeline control and lhn_mm, replacing the ad-hoc MAeff/WR_DM muxing.

Parameters:
AW, 10, memory address width
DW, 14, memory data width
STARVE_LIMIT, 3, consecutive IF losses (with if_req held) before IF is forced to win; 1..7

Ports:
Clock_pin  in  1  system clock, rising edge
Resetn_pin  in  1  asynchronous active-low reset
if_req  in  1  fetch request (read only)
if_addr  in  AW  fetch address
if_gnt  out  1  fetch granted this cycle
dm_req  in  1  data request
dm_we  in  1  1 = store, 0 = load
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_gnt  out  1  data granted this cycle
sk_req  in  1  stack request
sk_we  in  1  1 = push, 0 = pop
sk_lock  in  1  request a back-to-back second stack grant (CALL pushes PC+SR; RET pops both)
sk_addr  in  AW  stack address (SP)
sk_wdata  in  DW  push data
sk_gnt  out  1  stack granted this cycle
mem_addr  out  AW  registered address to memory
mem_wdata  out  DW  registered write data
mem_we  out  1  registered write strobe, one cycle per granted write
mem_rdata  in  DW  memory read data, valid by end of cycle after mem_addr changes
rdata  out  DW  registered read data, shared by all requesters
if_rvalid, dm_rvalid, sk_rvalid  out  1 each  rdata belongs to this requester this cycle

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: all gnt outputs 0; mem_we 0; mem_addr 0; mem_wdata 0; rdata 0; all rvalid 0; starve_cnt 0; FSM in NORMAL. A reset mid-operation drops any pending read; no rvalid follows.
- Grant timing: grants are combinational from the current requests and state. At most one gnt is high per cycle, and a gnt only goes high while its req is high.
- Requester handshake: a requester holds req, addr, we and wdata stable until it sees gnt. It may change or drop them in the following cycle.
- Memory outputs: registered on the edge ending grant cycle N, so mem_addr, mem_we and mem_wdata are valid in cycle N+1. mem_we returns to 0 in N+2 unless another write is granted.
- Read return: mem_rdata is captured on the edge ending N+1. rdata and the matching rvalid are high for exactly one cycle, N+2.
- Latency and throughput: grant to rvalid is 2 cycles; one access per cycle; back-to-back reads pipeline. A 2-entry shift of requester ID and read flag tracks outstanding reads. Writes never produce rvalid.
- With no grant: mem_we=0, mem_addr and mem_wdata hold their last values, no rvalid is generated.
- FSM states:
  - NORMAL: priority DM > SK > IF. Exception: if starve_cnt==STARVE_LIMIT and if_req=1, IF wins over everything.
  - NORMAL -> LOCKED: SK is granted with sk_lock=1.
  - LOCKED: if sk_req=1, SK is granted unconditionally, even over a starving IF, and the FSM returns to NORMAL. sk_lock is ignored in LOCKED, so the maximum is 2 consecutive locked grants. If sk_req=0, normal arbitration applies in the same cycle and the FSM returns to NORMAL.
- starve_cnt (3 bits):
  - 0 when if_req=0 or IF is granted.
  - Increments when if_req=1 and another requester is granted.
  - Holds when if_req=1 and there is no grant.
  - Saturates at STARVE_LIMIT.
- Simultaneous events:
  - All three requesting with starve_cnt<LIMIT: DM wins.
  - A DM request arriving in a LOCKED cycle waits.
  - A write granted in N followed by a read granted in N+1 to the same address returns the new data, because the memory performs the write in N+1 before the read in N+2.
- Address width: addresses are passed unmodified, with no wrap logic; SP wrap is the stack requester's concern.

Test Plan:
1. Reset while if_req=1 and a read is outstanding -> all gnt, mem_we and rvalid are 0 during reset; no rvalid after release; first if_gnt in the first cycle after release.
2. IF-only read of addr 0x005 (memory holds 0x1A2B), granted cycle N -> mem_addr=0x005 in N+1; rdata=0x1A2B with if_rvalid=1 only in N+2; the next fetch is granted in N+1 and its data returns in N+3.
3. dm_req (store 0x0123 to 0x010) and if_req together -> dm_gnt first; mem_we=1 with mem_addr=0x010 and mem_wdata=0x0123 for exactly one cycle; if_gnt the following cycle; no dm_rvalid.
4. DM held continuously with if_req held and STARVE_LIMIT=3 -> three dm_gnt, then if_gnt on the 4th cycle; starve_cnt then 0; DM resumes.
5. sk_req with sk_lock=1 (push 0x0ABC then 0x0123) while dm_req=1 -> sk_gnt on two consecutive cycles, dm_gnt on the third; a third sk request with sk_lock=1 is not granted before DM.
6. Store 0x3FFF to 0x020 granted in cycle N, then DM load of 0x020 granted in N+1 -> dm_rvalid in N+3 with rdata=0x3FFF.
